// File: rtl/rz_frame_tx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rz_frame_tx
// Description : Return-to-zero LED frame transmitter (WS2812-class strips).
//               Serialises pixel words MSB first with cycle-counted high/low
//               pulse widths and inserts a latch gap after each frame.
//               Optional macro RZ_BRIGHTNESS_EN adds a per-lane brightness
//               scaler applied when a word is accepted.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rz_frame_tx #(
   parameter int DATA_W    = 24,
   parameter int T_PERIOD  = 125,
   parameter int T0H       = 32,
   parameter int T1H       = 80,
   parameter int RESET_CYC = 30000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic              out,
   output logic              busy,
   output logic              frame_done,
   output logic              underrun
`ifdef RZ_BRIGHTNESS_EN
   ,
   input  logic [7:0]        brightness
`endif
);

   localparam int C_CNT_MAX = (T_PERIOD > RESET_CYC) ? T_PERIOD : RESET_CYC;
   localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
   localparam int C_IDX_W   = $clog2(DATA_W);
   localparam int C_LANES   = DATA_W / 8;

   localparam logic [C_CNT_W-1:0] C_PERIOD_END = C_CNT_W'(T_PERIOD - 1);
   localparam logic [C_CNT_W-1:0] C_RESET_END  = C_CNT_W'(RESET_CYC - 1);
   localparam logic [C_CNT_W-1:0] C_T0H        = C_CNT_W'(T0H);
   localparam logic [C_CNT_W-1:0] C_T1H        = C_CNT_W'(T1H);
   localparam logic [C_IDX_W-1:0] C_IDX_LAST   = C_IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_LATCH = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BIT   = 2'd2
   } state_t;

   state_t              r_state;
   logic [C_CNT_W-1:0]  r_cnt;
   logic [C_IDX_W-1:0]  r_bit_idx;
   logic [DATA_W-1:0]   r_sh;
   logic                r_last;
   logic                r_had_data;
   logic                r_out;
   logic                r_frame_done;
   logic                r_underrun;

   logic [DATA_W-1:0]   w_load;
   logic                w_final;
   logic                w_accept;
   logic [C_CNT_W-1:0]  w_cnt_inc;
   logic [C_CNT_W-1:0]  w_thr;

`ifdef RZ_BRIGHTNESS_EN
   // Each 8-bit lane is scaled by (brightness+1)/256; 255 leaves it unchanged.
   for (genvar g = 0; g < C_LANES; g++) begin : g_lane
      logic [15:0] w_prod;
      assign w_prod = 16'(in[8*g +: 8]) * (16'(brightness) + 16'd1);
      assign w_load[8*g +: 8] = w_prod[15:8];
   end
`else
   assign w_load = in;
`endif

   // Last slot of the last bit of the current pixel: the only in-frame chance
   // to take the next word without a gap.
   assign w_final   = (r_state == ST_BIT) && (r_bit_idx == C_IDX_LAST) &&
                      (r_cnt == C_PERIOD_END);
   assign s_ready   = (r_state == ST_IDLE) || (w_final && !r_last);
   assign busy      = (r_state != ST_IDLE);
   assign w_accept  = s_valid && s_ready;
   assign w_cnt_inc = r_cnt + C_CNT_W'(1);
   assign w_thr     = r_sh[DATA_W-1] ? C_T1H : C_T0H;

   assign out        = r_out;
   assign frame_done = r_frame_done;
   assign underrun   = r_underrun;

   // Frame sequencer: latch gap, idle wait and bit-slot timing; out is the
   // registered level for the slot position reached after this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_LATCH;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_sh         <= '0;
         r_last       <= 1'b0;
         r_had_data   <= 1'b0;
         r_out        <= 1'b0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
         case (r_state)
            ST_LATCH: begin
               r_out <= 1'b0;
               if (r_cnt == C_RESET_END) begin
                  r_state      <= ST_IDLE;
                  r_cnt        <= '0;
                  r_frame_done <= r_had_data;
                  r_had_data   <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_IDLE: begin
               r_out <= 1'b0;
               if (w_accept) begin
                  r_sh       <= w_load;
                  r_last     <= s_last;
                  r_had_data <= 1'b1;
                  r_cnt      <= '0;
                  r_bit_idx  <= '0;
                  r_state    <= ST_BIT;
                  r_out      <= 1'b1;
               end
            end
            ST_BIT: begin
               if (r_cnt != C_PERIOD_END) begin
                  r_cnt <= w_cnt_inc;
                  r_out <= (w_cnt_inc < w_thr);
               end else begin
                  r_cnt <= '0;
                  if (r_bit_idx != C_IDX_LAST) begin
                     // Next bit starts high whatever its value.
                     r_sh      <= {r_sh[DATA_W-2:0], 1'b0};
                     r_bit_idx <= r_bit_idx + C_IDX_W'(1);
                     r_out     <= 1'b1;
                  end else if (r_last) begin
                     r_state <= ST_LATCH;
                     r_out   <= 1'b0;
                  end else if (s_valid) begin
                     r_sh       <= w_load;
                     r_last     <= s_last;
                     r_had_data <= 1'b1;
                     r_bit_idx  <= '0;
                     r_out      <= 1'b1;
                  end else begin
                     // Starved mid-frame: latch whatever has been sent.
                     r_underrun <= 1'b1;
                     r_state    <= ST_LATCH;
                     r_out      <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_LATCH;
               r_cnt   <= '0;
               r_out   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rz_frame_tx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_rz_frame_tx
// Description : Directed self-checking bench for rz_frame_tx with
//               DATA_W=24, T_PERIOD=10, T0H=3, T1H=7, RESET_CYC=20.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rz_frame_tx;

   localparam int DW  = 24;
   localparam int TP  = 10;
   localparam int T0  = 3;
   localparam int T1  = 7;
   localparam int RC  = 20;
   localparam int PIX = DW * TP;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] px = '0;
   logic          s_valid = 1'b0;
   logic          s_last = 1'b0;
   logic          s_ready;
   logic          dout;
   logic          busy;
   logic          frame_done;
   logic          underrun;
`ifdef RZ_BRIGHTNESS_EN
   logic [7:0]    brightness = 8'd255;
`endif

   int vectors = 0;
   int miscompares = 0;

   rz_frame_tx #(
      .DATA_W(DW), .T_PERIOD(TP), .T0H(T0), .T1H(T1), .RESET_CYC(RC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in(px), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .out(dout), .busy(busy), .frame_done(frame_done),
      .underrun(underrun)
`ifdef RZ_BRIGHTNESS_EN
      , .brightness(brightness)
`endif
   );

   always #5 clk = ~clk;

   // Reference line level for data cycle d of a word w.
   function automatic logic exp_out(input logic [DW-1:0] w, input int d);
      int b;
      int c;
      b = DW - 1 - ((d / TP) % DW);
      c = d % TP;
      return (c < (w[b] ? T1 : T0));
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < RC; k++) begin
         vectors++;
         if (dout !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gap k=%0d: out=%b s_ready=%b busy=%b frame_done=%b, want 0 0 1 0",
                     k, dout, s_ready, busy, frame_done);
         end
         @(negedge clk);
      end
      vectors++;
      if (s_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: s_ready=%b busy=%b frame_done=%b, want 1 0 0", s_ready, busy, frame_done);
      end
   endtask

   task automatic test_single();
      px = 24'hA50000; s_last = 1'b1; s_valid = 1'b1;
      vectors++;
      if (s_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL single_ready: s_ready=%b want 1", s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
      for (int d = 0; d < PIX; d++) begin
         vectors++;
         if (dout !== exp_out(24'hA50000, d) || s_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_data d=%0d: out=%b s_ready=%b busy=%b, want %b 0 1",
                     d, dout, s_ready, busy, exp_out(24'hA50000, d));
         end
         @(negedge clk);
      end
      for (int l = 0; l < RC; l++) begin
         vectors++;
         if (dout !== 1'b0 || s_ready !== 1'b0 || frame_done !== 1'b0 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL single_latch l=%0d: out=%b s_ready=%b frame_done=%b underrun=%b, want 0 0 0 0",
                     l, dout, s_ready, frame_done, underrun);
         end
         @(negedge clk);
      end
      vectors++;
      if (frame_done !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done: frame_done=%b s_ready=%b busy=%b, want 1 1 0", frame_done, s_ready, busy);
      end
      @(negedge clk);
      vectors++;
      if (frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL single_done_width: frame_done=%b want 0", frame_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] w [3];
      int            ready_cnt;
      logic          exp_rdy;
      w[0] = 24'h123456; w[1] = 24'h00FF0F; w[2] = 24'hC3A5F0;
      ready_cnt = 0;
      px = w[0]; s_last = 1'b0; s_valid = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3 * PIX; d++) begin
         if (d == 0) px = w[1];
         if (d == PIX) begin px = w[2]; s_last = 1'b1; end
         if (d == 2 * PIX) s_valid = 1'b0;
         exp_rdy = (d == PIX - 1) || (d == 2 * PIX - 1);
         vectors++;
         if (dout !== exp_out(w[d / PIX], d) || s_ready !== exp_rdy ||
             underrun !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_data d=%0d: out=%b s_ready=%b underrun=%b frame_done=%b, want %b %b 0 0",
                     d, dout, s_ready, underrun, frame_done, exp_out(w[d / PIX], d), exp_rdy);
         end
         if (s_ready === 1'b1) ready_cnt++;
         @(negedge clk);
      end
      vectors++;
      if (ready_cnt != 2) begin
         miscompares++;
         $display("FAIL b2b_ready_count: got %0d want 2", ready_cnt);
      end
      for (int l = 0; l < RC; l++) begin
         vectors++;
         if (dout !== 1'b0 || s_ready !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_latch l=%0d: out=%b s_ready=%b frame_done=%b, want 0 0 0",
                     l, dout, s_ready, frame_done);
         end
         @(negedge clk);
      end
      vectors++;
      if (frame_done !== 1'b1 || s_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_done: frame_done=%b s_ready=%b, want 1 1", frame_done, s_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_underrun();
      logic [DW-1:0] w [2];
      logic          exp_rdy;
      w[0] = 24'h0F0F0F; w[1] = 24'hF0F0F0;
      px = w[0]; s_last = 1'b0; s_valid = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2 * PIX; d++) begin
         if (d == 0) px = w[1];
         if (d == PIX) s_valid = 1'b0;
         exp_rdy = (d == PIX - 1) || (d == 2 * PIX - 1);
         vectors++;
         if (dout !== exp_out(w[d / PIX], d) || s_ready !== exp_rdy || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL under_data d=%0d: out=%b s_ready=%b underrun=%b, want %b %b 0",
                     d, dout, s_ready, underrun, exp_out(w[d / PIX], d), exp_rdy);
         end
         @(negedge clk);
      end
      for (int l = 0; l < RC; l++) begin
         vectors++;
         if (dout !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1 ||
             underrun !== (l == 0) || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL under_latch l=%0d: out=%b s_ready=%b busy=%b underrun=%b frame_done=%b, want 0 0 1 %b 0",
                     l, dout, s_ready, busy, underrun, frame_done, (l == 0));
         end
         @(negedge clk);
      end
      vectors++;
      if (frame_done !== 1'b1 || s_ready !== 1'b1 || underrun !== 1'b0) begin
         miscompares++;
         $display("FAIL under_done: frame_done=%b s_ready=%b underrun=%b, want 1 1 0", frame_done, s_ready, underrun);
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      px = 24'hFFFFFF; s_last = 1'b1; s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      repeat (5 * TP + 2) @(negedge clk);
      vectors++;
      if (dout !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_high: out=%b want 1", dout);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (dout !== 1'b0 || underrun !== 1'b0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_async: out=%b underrun=%b frame_done=%b, want 0 0 0", dout, underrun, frame_done);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < RC; k++) begin
         vectors++;
         if (dout !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1 ||
             frame_done !== 1'b0 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_gap k=%0d: out=%b s_ready=%b busy=%b frame_done=%b underrun=%b, want 0 0 1 0 0",
                     k, dout, s_ready, busy, frame_done, underrun);
         end
         @(negedge clk);
      end
      vectors++;
      if (s_ready !== 1'b1 || frame_done !== 1'b0 || underrun !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_idle: s_ready=%b frame_done=%b underrun=%b, want 1 0 0", s_ready, frame_done, underrun);
      end
   endtask

`ifdef RZ_BRIGHTNESS_EN
   task automatic test_brightness();
      logic [DW-1:0] src [2];
      logic [DW-1:0] exp_w [2];
      logic [7:0]    br [2];
      src[0] = 24'hFF8000; exp_w[0] = 24'h7F4000; br[0] = 8'd127;
      src[1] = 24'h123456; exp_w[1] = 24'h123456; br[1] = 8'd255;
      for (int t = 0; t < 2; t++) begin
         brightness = br[t]; px = src[t]; s_last = 1'b1; s_valid = 1'b1;
         @(negedge clk);
         s_valid = 1'b0; brightness = 8'd0;
         for (int d = 0; d < PIX; d++) begin
            vectors++;
            if (dout !== exp_out(exp_w[t], d)) begin
               miscompares++;
               $display("FAIL bright t=%0d d=%0d: out=%b want %b", t, d, dout, exp_out(exp_w[t], d));
            end
            @(negedge clk);
         end
         repeat (RC) @(negedge clk);
         vectors++;
         if (frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL bright_done t=%0d: frame_done=%b want 1", t, frame_done);
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_underrun();
      test_mid_reset();
`ifdef RZ_BRIGHTNESS_EN
      test_brightness();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
